// File: rtl/axi_lite_slave_frontend_if.sv
// ============================================================================
// Module      : axi_lite_slave_frontend_if
// Description : AXI-Lite slave-side bus bundle (AW, W, B, AR, R channels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_slave_frontend_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_slave_frontend.sv
// ============================================================================
// Module      : axi_lite_slave_frontend
// Description : AXI-Lite slave converting bus writes/reads into word-addressed
//               datapath strobes, with independent write and read FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_slave_frontend #(
    parameter int ADDR_SHIFT = 0,
    parameter int RD_LATENCY = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    axi_lite_slave_frontend_if.slave   s_axi,
    output logic [31:0]                axi_wr_addr,
    output logic [31:0]                axi_wr_msg,
    output logic                       axi_wr_en,
    output logic [31:0]                axi_rd_addr,
    input  wire logic [31:0]           axi_rd_msg,
    output logic                       axi_rd_en
);

    localparam logic [1:0] c_resp_okay  = 2'b00;
    localparam logic [2:0] c_rd_latency = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_WAIT_A = 3'd1,
        W_WAIT_D = 3'd2,
        W_EXEC   = 3'd3,
        W_RESP   = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_msg;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic        r_rd_en;
    logic [31:0] r_rd_addr;
    logic [2:0]  r_rd_cnt;

    logic [31:0] w_aw_word;
    logic [31:0] w_ar_word;
    logic [3:0]  w_unused_wstrb;

    assign w_aw_word      = s_axi.s_awaddr >> ADDR_SHIFT;
    assign w_ar_word      = s_axi.s_araddr >> ADDR_SHIFT;
    // Byte strobes carry no meaning here: every write updates the full word.
    assign w_unused_wstrb = s_axi.s_wstrb;

    // Write path: address and data may arrive in either order or together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_resp_okay;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_msg   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    if (s_axi.s_awvalid) begin
                        r_wr_addr <= w_aw_word;
                    end
                    if (s_axi.s_wvalid) begin
                        r_wr_msg <= s_axi.s_wdata;
                    end
                    if (s_axi.s_awvalid && s_axi.s_wvalid) begin
                        r_wr_state <= W_EXEC;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_wr_en    <= 1'b1;
                    end else if (s_axi.s_awvalid) begin
                        r_wr_state <= W_WAIT_D;
                        r_awready  <= 1'b0;
                    end else if (s_axi.s_wvalid) begin
                        r_wr_state <= W_WAIT_A;
                        r_wready   <= 1'b0;
                    end
                end
                W_WAIT_D: begin
                    if (s_axi.s_wvalid) begin
                        r_wr_msg   <= s_axi.s_wdata;
                        r_wr_state <= W_EXEC;
                        r_wready   <= 1'b0;
                        r_wr_en    <= 1'b1;
                    end
                end
                W_WAIT_A: begin
                    if (s_axi.s_awvalid) begin
                        r_wr_addr  <= w_aw_word;
                        r_wr_state <= W_EXEC;
                        r_awready  <= 1'b0;
                        r_wr_en    <= 1'b1;
                    end
                end
                W_EXEC: begin
                    r_wr_state <= W_RESP;
                    r_bvalid   <= 1'b1;
                    r_bresp    <= c_resp_okay;
                end
                W_RESP: begin
                    if (s_axi.s_bready) begin
                        r_wr_state <= W_IDLE;
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                    r_bvalid   <= 1'b0;
                    r_awready  <= 1'b1;
                    r_wready   <= 1'b1;
                end
            endcase
        end
    end

    // Read path: the datapath is sampled once the latency counter expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rresp    <= c_resp_okay;
            r_rdata    <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_cnt   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (s_axi.s_arvalid) begin
                        r_rd_addr  <= w_ar_word;
                        r_rd_en    <= 1'b1;
                        r_rd_cnt   <= c_rd_latency;
                        r_arready  <= 1'b0;
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rd_cnt == 3'd0) begin
                        r_rdata    <= axi_rd_msg;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= c_resp_okay;
                        r_rd_en    <= 1'b0;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 3'd1;
                    end
                end
                R_RESP: begin
                    if (s_axi.s_rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                    r_rvalid   <= 1'b0;
                    r_rd_en    <= 1'b0;
                    r_arready  <= 1'b1;
                end
            endcase
        end
    end

    assign s_axi.s_awready = r_awready;
    assign s_axi.s_wready  = r_wready;
    assign s_axi.s_bvalid  = r_bvalid;
    assign s_axi.s_bresp   = r_bresp;
    assign s_axi.s_arready = r_arready;
    assign s_axi.s_rvalid  = r_rvalid;
    assign s_axi.s_rresp   = r_rresp;
    assign s_axi.s_rdata   = r_rdata;
    assign axi_wr_addr     = r_wr_addr;
    assign axi_wr_msg      = r_wr_msg;
    assign axi_wr_en       = r_wr_en;
    assign axi_rd_addr     = r_rd_addr;
    assign axi_rd_en       = r_rd_en;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_slave_frontend.sv
// ============================================================================
// Module      : tb_axi_lite_slave_frontend
// Description : Randomized self-checking bench for axi_lite_slave_frontend.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_lite_slave_frontend;

    localparam int ADDR_SHIFT = 2;
    localparam int RD_LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] axi_wr_addr;
    logic [31:0] axi_wr_msg;
    logic        axi_wr_en;
    logic [31:0] axi_rd_addr;
    logic [31:0] axi_rd_msg;
    logic        axi_rd_en;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    axi_lite_slave_frontend_if bus();

    axi_lite_slave_frontend #(
        .ADDR_SHIFT (ADDR_SHIFT),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_axi       (bus),
        .axi_wr_addr (axi_wr_addr),
        .axi_wr_msg  (axi_wr_msg),
        .axi_wr_en   (axi_wr_en),
        .axi_rd_addr (axi_rd_addr),
        .axi_rd_msg  (axi_rd_msg),
        .axi_rd_en   (axi_rd_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: a distinct word every cycle, so the sampled value pins down the sample cycle.
    function automatic logic [31:0] dp_word(input int c);
        return (32'(c) * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction
    assign axi_rd_msg = dp_word(cyc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit          aw_done = 1'b0;
        bit          w_done  = 1'b0;
        int          t       = 0;
        int          early   = 0;
        logic [31:0] exp_addr = addr >> ADDR_SHIFT;
        while (!(aw_done && w_done) && t < 40) begin
            @(posedge clk); #1;
            if (axi_wr_en) early++;
            check("awready_open", 32'(bus.s_awready), 32'(!aw_done));
            check("wready_open", 32'(bus.s_wready), 32'(!w_done));
            bus.s_awvalid = !aw_done && (t >= aw_dly);
            bus.s_awaddr  = bus.s_awvalid ? addr : $urandom;
            bus.s_wvalid  = !w_done && (t >= w_dly);
            bus.s_wdata   = bus.s_wvalid ? data : $urandom;
            bus.s_wstrb   = 4'($urandom);
            if (bus.s_awvalid && bus.s_awready) aw_done = 1'b1;
            if (bus.s_wvalid && bus.s_wready) w_done = 1'b1;
            t++;
        end
        check("wr_hs_timeout", 32'(aw_done && w_done), 32'd1);
        check("early_strobe", 32'(early), 32'd0);
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_awaddr  = $urandom;
        bus.s_wdata   = $urandom;
        bus.s_bready  = 1'b0;
        check("wr_en_pulse", 32'(axi_wr_en), 32'd1);
        check("wr_addr", axi_wr_addr, exp_addr);
        check("wr_msg", axi_wr_msg, data);
        check("bvalid_early", 32'(bus.s_bvalid), 32'd0);
        for (int i = 0; i <= b_dly; i++) begin
            @(posedge clk); #1;
            check("bvalid", 32'(bus.s_bvalid), 32'd1);
            check("bresp", 32'(bus.s_bresp), 32'd0);
            check("wr_en_resp", 32'(axi_wr_en), 32'd0);
            check("awready_resp", 32'(bus.s_awready), 32'd0);
            check("wready_resp", 32'(bus.s_wready), 32'd0);
            check("wr_addr_hold", axi_wr_addr, exp_addr);
            bus.s_bready = (i == b_dly);
        end
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        check("bvalid_done", 32'(bus.s_bvalid), 32'd0);
        check("wr_en_done", 32'(axi_wr_en), 32'd0);
        check("awready_back", 32'(bus.s_awready), 32'd1);
        check("wready_back", 32'(bus.s_wready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        bit          done = 1'b0;
        int          t    = 0;
        int          n    = 0;
        logic [31:0] exp_addr = addr >> ADDR_SHIFT;
        logic [31:0] exp_data;
        while (!done && t < 40) begin
            @(posedge clk); #1;
            check("arready_idle", 32'(bus.s_arready), 32'd1);
            bus.s_arvalid = (t >= ar_dly);
            bus.s_araddr  = bus.s_arvalid ? addr : $urandom;
            if (bus.s_arvalid && bus.s_arready) begin
                done = 1'b1;
                n    = cyc;
            end
            t++;
        end
        check("rd_hs_timeout", 32'(done), 32'd1);
        t = 0;
        while (1) begin
            @(posedge clk); #1;
            bus.s_arvalid = 1'b0;
            bus.s_araddr  = $urandom;
            if (bus.s_rvalid) break;
            check("rd_en_wait", 32'(axi_rd_en), 32'd1);
            check("arready_wait", 32'(bus.s_arready), 32'd0);
            check("rd_addr_wait", axi_rd_addr, exp_addr);
            t++;
            if (t > 20) begin
                check("rvalid_timeout", 32'd0, 32'd1);
                return;
            end
        end
        exp_data = dp_word(n + 1 + RD_LATENCY);
        check("rvalid_cycle", 32'(cyc), 32'(n + 2 + RD_LATENCY));
        check("rd_en_resp", 32'(axi_rd_en), 32'd0);
        for (int i = 0; i <= r_dly; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("rvalid_hold", 32'(bus.s_rvalid), 32'd1);
            check("rdata", bus.s_rdata, exp_data);
            check("rresp", 32'(bus.s_rresp), 32'd0);
            check("arready_resp", 32'(bus.s_arready), 32'd0);
            bus.s_arvalid = (i < r_dly);
            bus.s_araddr  = $urandom;
            bus.s_rready  = (i == r_dly);
        end
        @(posedge clk); #1;
        bus.s_rready  = 1'b0;
        bus.s_arvalid = 1'b0;
        check("rvalid_done", 32'(bus.s_rvalid), 32'd0);
        check("arready_back", 32'(bus.s_arready), 32'd1);
        check("rd_addr_kept", axi_rd_addr, exp_addr);
    endtask

    task automatic reset_abort_test();
        // Write handshake coincides with a reset edge: nothing may emerge.
        @(posedge clk); #1;
        bus.s_awvalid = 1'b1;
        bus.s_awaddr  = $urandom;
        bus.s_wvalid  = 1'b1;
        bus.s_wdata   = $urandom;
        reset         = 1'b1;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        reset         = 1'b0;
        check("rst_wr_addr", axi_wr_addr, 32'd0);
        check("rst_wr_msg", axi_wr_msg, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("rst_wr_en", 32'(axi_wr_en), 32'd0);
            check("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
            check("rst_awready", 32'(bus.s_awready), 32'd1);
            check("rst_wready", 32'(bus.s_wready), 32'd1);
        end
        // Reset while the read is waiting on the datapath.
        @(posedge clk); #1;
        bus.s_arvalid = 1'b1;
        bus.s_araddr  = 32'h0000_0018;
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_rd_addr", axi_rd_addr, 32'd0);
        check("rst_rdata", bus.s_rdata, 32'd0);
        for (int i = 0; i < RD_LATENCY + 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
            check("rst_rd_en", 32'(axi_rd_en), 32'd0);
            check("rst_arready", 32'(bus.s_arready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a0, d0, a1;
        int          x0, x1, x2, x3, x4;
        reset         = 1'b1;
        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("init_awready", 32'(bus.s_awready), 32'd1);
        check("init_wready", 32'(bus.s_wready), 32'd1);
        check("init_arready", 32'(bus.s_arready), 32'd1);
        check("init_bvalid", 32'(bus.s_bvalid), 32'd0);
        check("init_rvalid", 32'(bus.s_rvalid), 32'd0);
        check("init_wr_en", 32'(axi_wr_en), 32'd0);
        check("init_rd_en", 32'(axi_rd_en), 32'd0);
        check("init_wr_addr", axi_wr_addr, 32'd0);
        check("init_rd_addr", axi_rd_addr, 32'd0);
        check("init_rdata", bus.s_rdata, 32'd0);

        do_write(32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 0);
        do_write(32'h0000_0010, 32'h1234_5678, 3, 0, 0);
        do_write(32'h0000_0104, 32'hCAFE_F00D, 0, 2, 3);
        do_read(32'h0000_0018, 0, 0);
        do_read(32'h0000_0018, 1, 5);

        for (int k = 0; k < 25; k++) begin
            a0 = $urandom;
            d0 = $urandom;
            a1 = $urandom;
            x0 = $urandom_range(0, 3);
            x1 = $urandom_range(0, 3);
            x2 = $urandom_range(0, 3);
            x3 = $urandom_range(0, 3);
            x4 = $urandom_range(0, 5);
            fork
                do_write(a0, d0, x0, x1, x2);
                do_read(a1, x3, x4);
            join
        end

        reset_abort_test();
        do_write(32'hFFFF_FFFC, 32'h0BAD_F00D, 1, 0, 1);
        do_read(32'h8000_0000, 0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
